// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared definitions for the skid-buffered pipeline stage register.
// The state encoding doubles as the occupancy count.
package pipe_stage_skid_reg_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_EMPTY = 2'd0;
    localparam state_t ST_BUSY  = 2'd1;
    localparam state_t ST_FULL  = 2'd2;

    // Bubble/NOP payload for the common 64-bit PC+instruction stage.
    localparam logic [63:0] NOP_64 = 64'h0;

endpackage

// File: rtl/pipe_stage_skid_reg_slot.sv
// One payload slot: reset and clear both load FLUSH_VAL; otherwise load on demand.
module pipe_slot #(
    parameter int              DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            data_q <= FLUSH_VAL;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer,
// freeze/flush controls and a saturating flush-drop counter.
module pipe_stage_skid_reg
    import pipe_stage_skid_reg_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}},
    parameter int                CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam logic [CNT_W+1:0] DROP_MAX = {2'b00, {CNT_W{1'b1}}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W+1:0]  drop_sum;
    logic [DATA_W-1:0] main_q, skid_q, main_din;
    logic              main_ld, main_clr, skid_ld, skid_clr;
    logic              in_fire, out_fire;

    // Handshake is a function of registered state and controls only,
    // so in_ready never sees out_ready combinationally.
    assign in_ready  = (state_q != ST_FULL)  & ~freeze & ~flush & ~rst;
    assign out_valid = (state_q != ST_EMPTY) & ~freeze & ~flush & ~rst;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d  = state_q;
        main_ld  = 1'b0;
        main_clr = 1'b0;
        main_din = in_data;
        skid_ld  = 1'b0;
        skid_clr = 1'b0;
        if (flush) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_ld = 1'b1;
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_ld = 1'b1;
                    end else if (in_fire) begin
                        skid_ld = 1'b1;
                        state_d = ST_FULL;
                    end else if (out_fire) begin
                        main_clr = 1'b1;
                        state_d  = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_ld  = 1'b1;
                        main_din = skid_q;
                        skid_clr = 1'b1;
                        state_d  = ST_BUSY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    assign drop_sum = {2'b00, drop_q} + {{CNT_W{1'b0}}, state_q};

    always_comb begin
        drop_d = drop_q;
        if (flush) begin
            drop_d = (drop_sum > DROP_MAX) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    pipe_slot #(.DATA_W(DATA_W), .FLUSH_VAL(FLUSH_VAL)) u_main (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (main_clr),
        .load_i (main_ld),
        .d_i    (main_din),
        .q_o    (main_q)
    );

    pipe_slot #(.DATA_W(DATA_W), .FLUSH_VAL(FLUSH_VAL)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (skid_clr),
        .load_i (skid_ld),
        .d_i    (in_data),
        .q_o    (skid_q)
    );

    assign out_data  = main_q;
    assign occupancy = state_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench: default-width stage plus a CNT_W=2 copy for saturation.
module tb_pipe_stage_skid_reg;

    localparam logic [63:0] FV2 = 64'h0000_0000_0000_00EE;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, in_valid, out_ready;
    logic [63:0] in_data;

    logic        in_ready, out_valid;
    logic [63:0] out_data;
    logic [1:0]  occupancy;
    logic [7:0]  drop_cnt;

    logic        in_ready2, out_valid2;
    logic [63:0] out_data2;
    logic [1:0]  occupancy2;
    logic [1:0]  drop_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_skid_reg dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .drop_cnt(drop_cnt)
    );

    pipe_stage_skid_reg #(.DATA_W(64), .FLUSH_VAL(FV2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .occupancy(occupancy2), .drop_cnt(drop_cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_full(input logic [63:0] a, input logic [63:0] b);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = a;
        tick();
        in_data   = b;
        tick();
        in_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0;
        in_valid = 1'b1; in_data = 64'h55; out_ready = 1'b0;

        // Reset with in_valid high
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_in_ready", in_ready, 0);
            chk("rst_occ", occupancy, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_drop", drop_cnt, 0);
            chk("rst_out_data_sat", out_data2, FV2);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_occ", occupancy, 0);

        // Streaming at one beat per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h10 + 64'(i);
            #1;
            chk("stream_in_ready", in_ready, 1);
            tick();
            chk("stream_data", out_data, 64'h10 + 64'(i));
            chk("stream_valid", out_valid, 1);
            chk("stream_occ", occupancy, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("drain_occ", occupancy, 0);
        chk("drain_data", out_data, 0);
        chk("drain_valid", out_valid, 0);

        // Backpressure into FULL, then release
        push_full(64'hA, 64'hB);
        chk("bp_occ", occupancy, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_head", out_data, 64'hA);
        in_valid = 1'b1; in_data = 64'hC; out_ready = 1'b1;
        tick();
        chk("bp_second", out_data, 64'hB);
        chk("bp_occ_busy", occupancy, 1);
        chk("bp_ready_again", in_ready, 1);
        tick();
        chk("bp_third", out_data, 64'hC);
        chk("bp_occ_c", occupancy, 1);
        in_valid = 1'b0;
        tick();
        chk("bp_empty", occupancy, 0);

        // Freeze while FULL
        push_full(64'hA, 64'hB);
        freeze = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 64'hD;
        #1;
        chk("frz_out_valid", out_valid, 0);
        chk("frz_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_occ", occupancy, 2);
            chk("frz_head", out_data, 64'hA);
        end
        freeze = 1'b0; in_valid = 1'b0;
        #1;
        chk("unfrz_valid", out_valid, 1);
        chk("unfrz_head", out_data, 64'hA);
        tick();
        chk("unfrz_next", out_data, 64'hB);
        chk("unfrz_occ", occupancy, 1);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hE;
        tick();
        chk("refill_occ", occupancy, 2);

        // Flush over freeze with in_valid high
        flush = 1'b1; freeze = 1'b1; in_valid = 1'b1; in_data = 64'hF; out_ready = 1'b1;
        #1;
        chk("fl_in_ready", in_ready, 0);
        chk("fl_out_valid", out_valid, 0);
        tick();
        flush = 1'b0; freeze = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_occ", occupancy, 0);
        chk("fl_data", out_data, 0);
        chk("fl_drop", drop_cnt, 2);
        chk("fl_drop_sat", drop_cnt2, 2);
        chk("fl_data_sat", out_data2, FV2);
        chk("fl_valid", out_valid, 0);

        // Saturation on the CNT_W=2 instance
        push_full(64'h1, 64'h2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("sat1_drop", drop_cnt, 4);
        chk("sat1_drop_sat", drop_cnt2, 3);
        push_full(64'h3, 64'h4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("sat2_drop", drop_cnt, 6);
        chk("sat2_drop_sat", drop_cnt2, 3);

        // Flush from BUSY counts one
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h5;
        tick();
        in_valid = 1'b0;
        chk("busy_occ", occupancy, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("busy_fl_drop", drop_cnt, 7);
        chk("busy_fl_drop_sat", drop_cnt2, 3);
        tick();
        chk("hold_drop", drop_cnt, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
